uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default PAR_NONE, meaning parity mode: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 and 2.
REQ-006 SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port START, input, 1 bit: frame request, sampled on each rising CLK edge.
REQ-009 SHALL have port DATA, input, 9 bits: payload; only bits [DATA_BITS-1:0] are used.
REQ-010 SHALL have port BUSY, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-012 SHALL have port TX_LINE, output, 1 bit: serial line, driven from a register; idle level is high.

Function
REQ-013 SHALL use bit period DIV = (CLK_FREQ + BAUD/2) / BAUD, rounded to nearest; 50 MHz / 9600 gives DIV = 5208.
REQ-014 SHALL reject DIV < 2 and illegal DATA_BITS, PARITY or STOP_BITS values at elaboration.
REQ-015 SHALL size the divider counter to $clog2(DIV) bits; the counter counts 0..DIV-1, then wraps to 0 and issues a one-cycle bit tick.
REQ-016 SHALL implement FSM states IDLE, START_BIT, DATA, PARITY, STOP.
REQ-017 SHALL accept a frame in IDLE only, and only when START is high at a clock edge; DATA[DATA_BITS-1:0] is captured into a shift register on that same edge.
REQ-018 SHALL, on the accepting edge, set BUSY high, drive TX_LINE low (start bit), and clear the divider so the first bit lasts exactly DIV cycles.
REQ-019 SHALL ignore START while BUSY is high; the captured data is unaffected by DATA changes during a frame.
REQ-020 SHALL transmit data bits LSB first, each held for exactly DIV cycles.
REQ-021 SHALL visit PARITY only when PARITY != PAR_NONE; the parity bit is the XOR of the captured data bits (PAR_EVEN) or its inverse (PAR_ODD).
REQ-022 SHALL drive STOP high for STOP_BITS*DIV cycles.
REQ-023 SHALL make total frame length exactly DIV*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if parity is enabled, else 0.
REQ-024 SHALL, on the edge that ends the last stop bit, return to IDLE, drop BUSY, and assert DONE for exactly one cycle.
REQ-025 SHALL accept a START that is high during the DONE cycle on the next edge (back-to-back), with no extra idle bit.
REQ-026 SHALL hold TX_LINE high and the divider at 0 in IDLE.

Reset
REQ-027 SHALL, while RST is high at a clock edge, set state=IDLE, TX_LINE=1, BUSY=0, DONE=0, and clear the divider, bit index and shift register.
REQ-028 SHALL abort any in-progress frame when RST asserts, with TX_LINE high on the following cycle, and SHALL NOT pulse DONE.
REQ-029 SHALL give RST priority over START on the same edge.

Structure
REQ-030 SHALL place the parity-mode enum (PAR_NONE/PAR_EVEN/PAR_ODD), the FSM state typedef and a uart_div() rounding function in shared package uart_pkg.
REQ-031 SHALL implement the divider as sub-module uart_baud_gen (parameter DIV; inputs CLK, RST, EN, CLR; output TICK).

Verification (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10)
REQ-032 SHALL cover: 8N1, DATA=0x55 → TX_LINE sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles; BUSY high for 100 cycles; one DONE pulse.
REQ-033 SHALL cover: 7E2, DATA=0x03 → 7 data bits, then parity 0, then 2 stop bits; frame lasts 110 cycles.
REQ-034 SHALL cover: 8O1, DATA=0xFF → parity bit 1; 8O1, DATA=0x00 → parity bit 1.
REQ-035 SHALL cover: START held continuously with DATA=0xA5 then 0x3C → two contiguous frames with no idle gap; DATA changed mid-frame → no effect on the current frame.
REQ-036 SHALL cover: RST asserted at cycle 35 of a frame → TX_LINE=1 and BUSY=0 the next cycle, no DONE; a new START afterwards produces a correct full frame.
REQ-037 SHALL cover: default parameters → bit period of 5208 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, transmitter FSM states and the baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_BIT = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the wrap cycle.
module uart_baud_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap_c;

  assign wrap_c = (cnt_q == CW'(DIV - 1));
  assign TICK   = EN && wrap_c;

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      cnt_q <= '0;
    end else if (EN) begin
      cnt_q <= wrap_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter parity_e     PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [8:0] DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       TX_LINE
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
  localparam int unsigned IW  = 4;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: bit period DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be PAR_NONE, PAR_EVEN or PAR_ODD");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 unused_data;

  // Bits above DATA_BITS are intentionally ignored.
  assign unused_data = ^DATA;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (state_q != ST_IDLE),
    .CLR  (state_q == ST_IDLE),
    .TICK (tick)
  );

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (START) begin
          state_d = ST_START_BIT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          shreg_d = DATA[DATA_BITS-1:0];
          par_d   = (PARITY == PAR_ODD) ^ (^DATA[DATA_BITS-1:0]);
          idx_d   = '0;
        end
      end
      ST_START_BIT: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shreg_q[0];
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            idx_d   = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign TX_LINE = tx_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 7E2, 8O1 and default-parameter instances.
module tb_uart_tx_param;
  import uart_pkg::*;

  logic       CLK;
  logic       RST;
  logic [3:0] start;
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] tx;
  logic [8:0] data [4];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
    .CLK(CLK), .RST(RST), .START(start[0]), .DATA(data[0]),
    .BUSY(busy[0]), .DONE(done[0]), .TX_LINE(tx[0]));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
                  .PARITY(PAR_EVEN), .STOP_BITS(2)) u_7e2 (
    .CLK(CLK), .RST(RST), .START(start[1]), .DATA(data[1]),
    .BUSY(busy[1]), .DONE(done[1]), .TX_LINE(tx[1]));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                  .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
    .CLK(CLK), .RST(RST), .START(start[2]), .DATA(data[2]),
    .BUSY(busy[2]), .DONE(done[2]), .TX_LINE(tx[2]));

  uart_tx_param u_def (
    .CLK(CLK), .RST(RST), .START(start[3]), .DATA(data[3]),
    .BUSY(busy[3]), .DONE(done[3]), .TX_LINE(tx[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called in frame cycle 0; returns in the DONE cycle. exp[i] is the line level of bit i.
  task automatic check_frame(input string tag, input int inst, input logic [11:0] exp,
                             input int nbits, input int div,
                             input int chg_cycle, input logic [8:0] chg_data);
    int  cyc = 0;
    int  done_seen = 0;
    logic ok;
    for (int b = 0; b < nbits; b++) begin
      ok = 1'b1;
      for (int c = 0; c < div; c++) begin
        if (cyc == chg_cycle) data[inst] = chg_data;
        if (tx[inst] !== exp[b] || busy[inst] !== 1'b1) ok = 1'b0;
        if (done[inst] !== 1'b0) done_seen++;
        cyc++;
        @(negedge CLK);
      end
      chk($sformatf("%s bit%0d", tag, b), 32'(ok), 32'd1);
    end
    chk($sformatf("%s early_done", tag), 32'(done_seen), 32'd0);
    chk($sformatf("%s done_pulse", tag), 32'(done[inst]), 32'd1);
    chk($sformatf("%s busy_end", tag), 32'(busy[inst]), 32'd0);
    chk($sformatf("%s tx_end", tag), 32'(tx[inst]), 32'd1);
  endtask

  task automatic launch(input int inst, input logic [8:0] d);
    start[inst] = 1'b1;
    data[inst]  = d;
    @(negedge CLK);
    start[inst] = 1'b0;
  endtask

  task automatic after_done(input string tag, input int inst);
    @(negedge CLK);
    chk($sformatf("%s done_one_cycle", tag), 32'(done[inst]), 32'd0);
    chk($sformatf("%s idle_tx", tag), 32'(tx[inst]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int dn;
    RST   = 1'b1;
    start = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    repeat (3) @(negedge CLK);
    chk("reset tx 8n1", 32'(tx[0]), 32'd1);
    chk("reset busy 8n1", 32'(busy[0]), 32'd0);
    chk("reset done 8n1", 32'(done[0]), 32'd0);
    chk("reset tx def", 32'(tx[3]), 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle busy 7e2", 32'(busy[1]), 32'd0);

    launch(0, 9'h055);
    check_frame("8n1_55", 0, 12'h2AA, 10, 10, -1, 9'h000);
    after_done("8n1_55", 0);

    // Bits above DATA_BITS set to check they are ignored.
    launch(1, 9'h183);
    check_frame("7e2_03", 1, 12'h606, 11, 10, -1, 9'h000);
    after_done("7e2_03", 1);

    launch(2, 9'h0FF);
    check_frame("8o1_ff", 2, 12'h7FE, 11, 10, -1, 9'h000);
    after_done("8o1_ff", 2);
    launch(2, 9'h000);
    check_frame("8o1_00", 2, 12'h600, 11, 10, -1, 9'h000);
    after_done("8o1_00", 2);

    // START held: second frame must start right after the DONE cycle.
    start[0] = 1'b1;
    data[0]  = 9'h0A5;
    @(negedge CLK);
    check_frame("b2b_a5", 0, 12'h34A, 10, 10, 20, 9'h03C);
    @(negedge CLK);
    start[0] = 1'b0;
    check_frame("b2b_3c", 0, 12'h278, 10, 10, -1, 9'h000);
    after_done("b2b_3c", 0);

    // Abort at cycle 35 of a frame.
    launch(0, 9'h055);
    repeat (35) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort tx", 32'(tx[0]), 32'd1);
    chk("abort busy", 32'(busy[0]), 32'd0);
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      if (done[0] !== 1'b0 || tx[0] !== 1'b1) dn++;
      @(negedge CLK);
    end
    chk("abort quiet", 32'(dn), 32'd0);
    launch(0, 9'h0A5);
    check_frame("post_abort_a5", 0, 12'h34A, 10, 10, -1, 9'h000);
    after_done("post_abort_a5", 0);

    // Reset wins over START on the same edge.
    RST      = 1'b1;
    start[0] = 1'b1;
    data[0]  = 9'h000;
    @(negedge CLK);
    RST      = 1'b0;
    start[0] = 1'b0;
    chk("rst_prio busy", 32'(busy[0]), 32'd0);
    chk("rst_prio tx", 32'(tx[0]), 32'd1);
    @(negedge CLK);
    chk("rst_prio still idle", 32'(busy[0]), 32'd0);

    // Default parameters: start bit spans 5208 cycles.
    launch(3, 9'h001);
    cnt = 0;
    while (tx[3] === 1'b0 && cnt < 6000) begin
      cnt++;
      @(negedge CLK);
    end
    chk("default bit period", 32'(cnt), 32'd5208);
    chk("default busy", 32'(busy[3]), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("default abort busy", 32'(busy[3]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
